// File: rtl/uart_tx_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer_if
// Brief    : TX FIFO read-port handshake (empty flag, pop strobe, read data).
// Revision : 1.0  initial release
// ============================================================================
interface uart_tx_serializer_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  fifo_empty;
   logic                  pop;
   logic [DATA_WIDTH-1:0] rdata;

   // master = serializer (issues pops), slave = FIFO read port
   modport master (input fifo_empty, input rdata, output pop);
   modport slave  (output fifo_empty, output rdata, input pop);
endinterface
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer
// Brief    : Pops bytes from the TX FIFO and serializes them as UART frames.
//            Define UART_TX_PARITY_EN to build the optional parity bit.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_serializer #(
   parameter int DATA_WIDTH = 8,
   parameter int DIV_WIDTH  = 16
) (
   input  wire logic                 i_clk,
   input  wire logic                 i_rst_n,
   uart_tx_serializer_if.master      fifo_rd,
   input  wire logic                 i_en,
   input  wire logic [DIV_WIDTH-1:0] i_baud_div,
   input  wire logic                 i_parity_en,
   input  wire logic                 i_parity_odd,
   input  wire logic                 i_stop2,
   output logic                      o_txd,
   output logic                      o_busy,
   output logic                      o_frame_done
);

   localparam int c_cnt_w = $clog2(DATA_WIDTH + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      START  = 3'd2,
      DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
      PARITY = 3'd4,
`endif
      STOP   = 3'd5
   } state_t;

   state_t                r_state;
   logic                  r_txd;
   logic                  r_pop;
   logic                  r_busy;
   logic                  r_frame_done;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [c_cnt_w-1:0]    r_bit_cnt;
   logic [DIV_WIDTH-1:0]  r_baud_cnt;
   logic [DIV_WIDTH-1:0]  r_div_m1;
   logic                  r_stop2;
   logic                  r_last_stop;
`ifdef UART_TX_PARITY_EN
   logic                  r_par_en;
   logic                  r_par_bit;
`else
   logic                  w_unused_parity;
   assign w_unused_parity = i_parity_en ^ i_parity_odd;
`endif

   logic [DIV_WIDTH-1:0]  w_div_m1;
   logic                  w_bit_end;
   logic                  w_start_ok;
   logic [DATA_WIDTH-1:0] w_shift_nxt;

   // Divisors below 2 are clamped so the stop bit always has a pre-final cycle
   assign w_div_m1    = (i_baud_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(1) : i_baud_div - DIV_WIDTH'(1);
   assign w_bit_end   = (r_baud_cnt == '0);
   assign w_start_ok  = i_en & ~fifo_rd.fifo_empty;
   assign w_shift_nxt = {1'b0, r_shift[DATA_WIDTH-1:1]};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= IDLE;
         r_txd        <= 1'b1;
         r_pop        <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_shift      <= '0;
         r_bit_cnt    <= '0;
         r_baud_cnt   <= '0;
         r_div_m1     <= '0;
         r_stop2      <= 1'b0;
         r_last_stop  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_par_en     <= 1'b0;
         r_par_bit    <= 1'b0;
`endif
      end else begin
         r_pop        <= 1'b0;
         r_frame_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_txd <= 1'b1;
               if (r_pop) begin
                  r_state <= FETCH;
                  r_busy  <= 1'b1;
               end else if (w_start_ok) begin
                  r_pop <= 1'b1;
               end
            end
            FETCH: begin
               r_shift    <= fifo_rd.rdata;
               r_div_m1   <= w_div_m1;
               r_baud_cnt <= w_div_m1;
               r_stop2    <= i_stop2;
`ifdef UART_TX_PARITY_EN
               r_par_en   <= i_parity_en;
               r_par_bit  <= (^fifo_rd.rdata) ^ i_parity_odd;
`endif
               r_txd      <= 1'b0;
               r_state    <= START;
            end
            START: begin
               if (w_bit_end) begin
                  r_txd      <= r_shift[0];
                  r_shift    <= w_shift_nxt;
                  r_bit_cnt  <= c_cnt_w'(1);
                  r_baud_cnt <= r_div_m1;
                  r_state    <= DATA;
               end else begin
                  r_baud_cnt <= r_baud_cnt - DIV_WIDTH'(1);
               end
            end
            DATA: begin
               if (!w_bit_end) begin
                  r_baud_cnt <= r_baud_cnt - DIV_WIDTH'(1);
               end else if (r_bit_cnt != c_cnt_w'(DATA_WIDTH)) begin
                  r_txd      <= r_shift[0];
                  r_shift    <= w_shift_nxt;
                  r_bit_cnt  <= r_bit_cnt + c_cnt_w'(1);
                  r_baud_cnt <= r_div_m1;
               end else begin
                  r_bit_cnt  <= '0;
                  r_baud_cnt <= r_div_m1;
`ifdef UART_TX_PARITY_EN
                  if (r_par_en) begin
                     r_txd   <= r_par_bit;
                     r_state <= PARITY;
                  end else begin
                     r_txd       <= 1'b1;
                     r_last_stop <= ~r_stop2;
                     r_state     <= STOP;
                  end
`else
                  r_txd       <= 1'b1;
                  r_last_stop <= ~r_stop2;
                  r_state     <= STOP;
`endif
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (w_bit_end) begin
                  r_txd       <= 1'b1;
                  r_last_stop <= ~r_stop2;
                  r_baud_cnt  <= r_div_m1;
                  r_state     <= STOP;
               end else begin
                  r_baud_cnt <= r_baud_cnt - DIV_WIDTH'(1);
               end
            end
`endif
            STOP: begin
               r_txd <= 1'b1;
               if (!w_bit_end) begin
                  r_baud_cnt <= r_baud_cnt - DIV_WIDTH'(1);
                  // Registered strobes must be set one cycle ahead of the final stop cycle
                  if (r_last_stop && (r_baud_cnt == DIV_WIDTH'(1))) begin
                     r_frame_done <= 1'b1;
                     r_pop        <= w_start_ok;
                  end
               end else if (!r_last_stop) begin
                  r_last_stop <= 1'b1;
                  r_baud_cnt  <= r_div_m1;
               end else if (r_pop) begin
                  r_state <= FETCH;
               end else begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_txd   <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign fifo_rd.pop  = r_pop;
   assign o_txd        = r_txd;
   assign o_busy       = r_busy;
   assign o_frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Transmit-side consumer of the TX FIFO read port. It pops bytes from the FIFO, serializes each one onto a UART line (start, data LSB-first, optional parity, 1 or 2 stop bits) at a programmable bit period, and reports frame status. It runs entirely in the FIFO read-clock domain.

## Interface
- DATA_WIDTH, 8, data bits per frame and FIFO word width; legal range 5..9.
- DIV_WIDTH, 16, width of the bit-period divisor.

- i_clk  input  1  FIFO read-side clock.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_en  input  1  transmit enable; sampled only at frame boundaries.
- i_fifo_empty  input  1  FIFO empty flag.
- o_pop  output  1  FIFO pop strobe, one cycle wide.
- i_rdata  input  DATA_WIDTH  FIFO read data, valid the cycle after o_pop.
- i_baud_div  input  DIV_WIDTH  clock cycles per bit; values 0 and 1 are treated as 2.
- i_parity_en  input  1  append a parity bit.
- i_parity_odd  input  1  1 selects odd parity, 0 selects even.
- i_stop2  input  1  two stop bits when 1.
- o_txd  output  1  serial line, idle high.
- o_busy  output  1  high from FETCH through the last stop-bit cycle.
- o_frame_done  output  1  one-cycle pulse during the final cycle of the last stop bit.

## Operation
- FSM states: IDLE, FETCH, START, DATA, PARITY, STOP.
- IDLE: o_txd=1. If i_en & !i_fifo_empty, assert o_pop for one cycle and go to FETCH.
- FETCH: o_txd=1. Capture i_rdata into the shift register. Latch i_baud_div (N), i_parity_en, i_parity_odd and i_stop2; these stay frozen for the whole frame. Go to START.
- START: o_txd=0 for N cycles, then go to DATA.
- DATA: DATA_WIDTH bits, LSB first, N cycles each. Bit counter width is $clog2(DATA_WIDTH+1). Afterwards go to PARITY if parity is enabled, else STOP.
- PARITY: even parity is ^data; odd parity is ~^data. Held N cycles.
- STOP: o_txd=1 for N or 2N cycles. In the final cycle, pulse o_frame_done. If i_en & !i_fifo_empty in that cycle, assert o_pop and go to FETCH; otherwise go to IDLE.
- The baud counter counts down from N-1 to 0. The bit advances on 0.
- Reset values: o_txd=1, o_pop=0, o_busy=0, o_frame_done=0, state=IDLE, all counters 0.
- Deasserting i_en mid-frame does not abort the frame. The frame completes and no further pop is issued.
- A change to i_baud_div or the parity/stop inputs mid-frame has no effect until the next FETCH.
- o_pop is never asserted while i_fifo_empty=1.
- o_pop is never asserted in any state other than IDLE or the last STOP cycle.
- Reset asserted mid-frame: o_txd goes high immediately (asynchronous) and the FSM returns to IDLE. The byte in flight is lost.

## Timing
- Pop in cycle T gives FETCH at T+1 and START (o_txd falling edge) at T+2.
- Frame length is N×(1 + DATA_WIDTH + P + S) cycles from T+2, where P is 0 or 1 and S is 1 or 2.
- Back-to-back frames: exactly one extra idle-high cycle (FETCH) between the last stop bit and the next start bit.
- o_pop and o_frame_done coincide in the back-to-back case.
- All outputs are registered.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state and parity logic are built, and i_parity_en and i_parity_odd are honored.
- UART_TX_PARITY_EN undefined: no PARITY state is built, i_parity_en and i_parity_odd are ignored, and the frame is always start + data + stop. Port list is unchanged.

## Test plan
- N=4, 8N1, FIFO holds 0x55, pop at T -> o_txd low T+2..T+5, then 1,0,1,0,1,0,1,0 at 4 cycles each, stop high T+38..T+41, o_frame_done at T+41, o_busy low at T+42.
- Parity enabled, even, data 0x07 -> parity bit 1; odd -> parity bit 0. Stop bit follows the parity bit; 11-bit frame of 44 cycles at N=4.
- Two bytes 0xA3, 0x3C queued -> second o_pop at T+41 together with o_frame_done; o_txd high at T+42; second start bit at T+43; bytes appear LSB first.
- i_baud_div=0 and then 1 -> every bit is 2 cycles; i_stop2=1 -> stop held 4 cycles.
- i_fifo_empty=1 with i_en=1 for 100 cycles -> o_pop never asserted, o_txd=1, o_busy=0. i_en=0 with data queued -> no pop.
- i_rst_n low during DATA bit 3 -> o_txd=1 within the same cycle, all outputs at reset values. After release, a queued byte is fetched with a fresh pop.
